// File: rtl/timer_capture_if.sv
// Configuration, measured signal and result bundle for timer_capture.
// The master side drives capture setup and the pulse stream; the slave side is the capture block.
interface timer_capture_if;
    logic       cap_en;
    logic [1:0] mode;
    logic [7:0] window;
    logic       sig_in;
    logic [7:0] cap_value;
    logic       cap_valid;
    logic       overflow;
    logic       busy;

    modport master (
        output cap_en, mode, window, sig_in,
        input  cap_value, cap_valid, overflow, busy
    );

    modport slave (
        input  cap_en, mode, window, sig_in,
        output cap_value, cap_valid, overflow, busy
    );
endinterface

// File: rtl/timer_capture.sv
// Input-capture unit: measures high-pulse width, rise-to-rise period or rising-edge
// count over a window on a synchronized pulse stream, reporting 8-bit saturating results.
module timer_capture #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    timer_capture_if.slave cap_if
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARM     = 2'b01,
        MEASURE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_WIDTH  = 2'b00,
        MODE_PERIOD = 2'b01,
        MODE_EDGE   = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

    state_e                 state_q, state_d;
    mode_e                  mode_q, mode_d;
    mode_e                  mode_in;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sig_d_q, sig_d_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [8:0]             win_q, win_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             cap_value_q, cap_value_d;
    logic                   cap_valid_q, cap_valid_d;
    logic                   overflow_q, overflow_d;
    logic                   busy_q, busy_d;

    logic                   sig_s, rise, fall, abort;
    logic [7:0]             cnt_inc;
    logic                   ovf_inc;
    logic [7:0]             cnt_edge;
    logic                   ovf_edge;
    logic [8:0]             win_load;

    assign mode_in  = mode_e'(cap_if.mode);
    assign sig_s    = sync_q[SYNC_STAGES-1];
    assign rise     = sig_s & ~sig_d_q;
    assign fall     = ~sig_s & sig_d_q;
    assign abort    = !cap_if.cap_en || (mode_in == MODE_OFF) || (mode_in != mode_q);
    // A window of 0 stands for 256 cycles, hence the 9-bit window counter.
    assign win_load = {cap_if.window == 8'd0, cap_if.window};

    assign cap_if.cap_value = cap_value_q;
    assign cap_if.cap_valid = cap_valid_q;
    assign cap_if.overflow  = overflow_q;
    assign cap_if.busy      = busy_q;

    always_comb begin
        cnt_inc = cnt_q;
        ovf_inc = ovf_q;
        if (cnt_q == 8'hFF) begin
            ovf_inc = 1'b1;
        end else begin
            cnt_inc = cnt_q + 8'd1;
        end
        cnt_edge = rise ? cnt_inc : cnt_q;
        ovf_edge = rise ? ovf_inc : ovf_q;
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        sync_d      = {sync_q[SYNC_STAGES-2:0], cap_if.sig_in};
        sig_d_d     = sig_s;
        cnt_d       = cnt_q;
        win_d       = win_q;
        ovf_d       = ovf_q;
        cap_value_d = cap_value_q;
        cap_valid_d = 1'b0;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (cap_if.cap_en && (mode_in != MODE_OFF)) begin
                    state_d = ARM;
                    mode_d  = mode_in;
                    if (mode_in == MODE_EDGE) begin
                        win_d = win_load;
                    end
                end
            end
            ARM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (mode_q == MODE_EDGE) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = 8'd1;
                    ovf_d   = 1'b0;
                end
            end
            MEASURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    case (mode_q)
                        MODE_WIDTH: begin
                            if (fall) begin
                                cap_value_d = cnt_q;
                                overflow_d  = ovf_q;
                                cap_valid_d = 1'b1;
                                state_d     = ARM;
                            end else if (sig_s) begin
                                cnt_d = cnt_inc;
                                ovf_d = ovf_inc;
                            end
                        end
                        MODE_PERIOD: begin
                            // A rise landing on a full counter is reported as saturated.
                            if (rise) begin
                                cap_value_d = cnt_q;
                                overflow_d  = ovf_q | (cnt_q == 8'hFF);
                                cap_valid_d = 1'b1;
                                cnt_d       = 8'd1;
                                ovf_d       = 1'b0;
                            end else begin
                                cnt_d = cnt_inc;
                                ovf_d = ovf_inc;
                            end
                        end
                        MODE_EDGE: begin
                            if (win_q == 9'd1) begin
                                cap_value_d = cnt_edge;
                                overflow_d  = ovf_edge;
                                cap_valid_d = 1'b1;
                                win_d       = win_load;
                                cnt_d       = '0;
                                ovf_d       = 1'b0;
                            end else begin
                                win_d = win_q - 9'd1;
                                cnt_d = cnt_edge;
                                ovf_d = ovf_edge;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_WIDTH;
            sync_q      <= '0;
            sig_d_q     <= 1'b0;
            cnt_q       <= '0;
            win_q       <= '0;
            ovf_q       <= 1'b0;
            cap_value_q <= '0;
            cap_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            sync_q      <= sync_d;
            sig_d_q     <= sig_d_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            ovf_q       <= ovf_d;
            cap_value_q <= cap_value_d;
            cap_valid_q <= cap_valid_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
        end
    end
endmodule

// File: tb/tb_timer_capture.sv
// Directed bench for timer_capture: logs every cap_valid strobe and compares the
// log against hand-computed widths, periods, edge counts, overflow and abort behaviour.
module tb_timer_capture;
    logic        clk;
    logic        rst;
    int unsigned edge_n;
    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned drv_edge;

    logic [7:0]  q_val[$];
    logic        q_ovf[$];
    int unsigned q_edge[$];

    timer_capture_if bus ();

    timer_capture #(.SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .cap_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_n = 0;
    always @(posedge clk) edge_n++;

    always @(negedge clk) begin
        if (bus.cap_valid === 1'b1) begin
            q_val.push_back(bus.cap_value);
            q_ovf.push_back(bus.overflow);
            q_edge.push_back(edge_n);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] log_val(input int unsigned i);
        return (q_val.size() > i) ? {24'd0, q_val[i]} : 32'hDEAD;
    endfunction

    function automatic logic [31:0] log_ovf(input int unsigned i);
        return (q_ovf.size() > i) ? {31'd0, q_ovf[i]} : 32'hDEAD;
    endfunction

    function automatic logic [31:0] log_gap(input int unsigned i);
        return (q_edge.size() > i + 1) ? q_edge[i+1] - q_edge[i] : 32'hDEAD;
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int unsigned hi, input int unsigned lo);
        bus.sig_in = 1'b1;
        tick(hi);
        bus.sig_in = 1'b0;
        tick(lo);
    endtask

    task automatic clear_log();
        q_val.delete();
        q_ovf.delete();
        q_edge.delete();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst        = 1'b1;
        bus.cap_en = 1'b0;
        bus.mode   = 2'b11;
        bus.window = 8'd0;
        bus.sig_in = 1'b0;

        // Reset with the input toggling
        for (int i = 0; i < 2; i++) begin
            bus.sig_in = ~bus.sig_in;
            tick(1);
        end
        check_eq("rst_value", bus.cap_value, 0);
        check_eq("rst_valid", bus.cap_valid, 0);
        check_eq("rst_ovf",   bus.overflow,  0);
        check_eq("rst_busy",  bus.busy,      0);
        rst        = 1'b0;
        bus.sig_in = 1'b0;
        tick(4);
        check_eq("idle_busy", bus.busy, 0);

        // Pulse width: 5 cycles high
        bus.cap_en = 1'b1;
        bus.mode   = 2'b00;
        tick(2);
        check_eq("arm_busy", bus.busy, 1);
        clear_log();
        bus.sig_in = 1'b1;
        tick(5);
        bus.sig_in = 1'b0;
        drv_edge   = edge_n;
        tick(6);
        check_eq("width_count",   q_val.size(), 1);
        check_eq("width_value",   log_val(0), 5);
        check_eq("width_ovf",     log_ovf(0), 0);
        check_eq("width_latency", (q_edge.size() > 0) ? q_edge[0] - drv_edge : 32'hDEAD, 3);

        // Period: square wave 5/5, four periods
        bus.mode = 2'b01;
        tick(3);
        clear_log();
        repeat (4) pulse(5, 5);
        check_eq("period_count", q_val.size(), 3);
        for (int unsigned i = 0; i < 3; i++) begin
            check_eq($sformatf("period_value%0d", i), log_val(i), 10);
            check_eq($sformatf("period_ovf%0d", i),   log_ovf(i), 0);
        end
        check_eq("period_gap", log_gap(0), 10);

        // Edge count: window 20, square wave period 4
        clear_log();
        bus.mode   = 2'b10;
        bus.window = 8'd20;
        repeat (40) pulse(2, 2);
        check_eq("edge20_count", q_val.size(), 7);
        for (int unsigned i = 0; i < 7; i++) begin
            check_eq($sformatf("edge20_value%0d", i), log_val(i), 5);
        end
        check_eq("edge20_gap", log_gap(2), 20);

        // Window 0 means 256 cycles; takes effect at the next reload
        clear_log();
        bus.window = 8'd0;
        repeat (150) pulse(2, 2);
        check_eq("edge256_count",  q_val.size(), 3);
        check_eq("edge256_first",  log_val(0), 5);
        check_eq("edge256_value1", log_val(1), 64);
        check_eq("edge256_value2", log_val(2), 64);
        check_eq("edge256_gap",    log_gap(1), 256);

        // Overflow: 300-cycle pulse saturates, next short pulse is clean
        bus.mode = 2'b00;
        tick(4);
        clear_log();
        pulse(300, 6);
        pulse(3, 6);
        check_eq("ovf_count",     q_val.size(), 2);
        check_eq("ovf_value",     log_val(0), 255);
        check_eq("ovf_flag",      log_ovf(0), 1);
        check_eq("ovf_next",      log_val(1), 3);
        check_eq("ovf_next_flag", log_ovf(1), 0);

        // Abort by dropping cap_en mid-pulse
        clear_log();
        bus.sig_in = 1'b1;
        tick(4);
        check_eq("abort_en_busy_before", bus.busy, 1);
        bus.cap_en = 1'b0;
        tick(1);
        check_eq("abort_en_busy", bus.busy, 0);
        tick(3);
        bus.sig_in = 1'b0;
        tick(6);
        check_eq("abort_en_strobes", q_val.size(), 0);
        check_eq("abort_en_hold",    bus.cap_value, 3);

        // Abort by mode change mid-pulse, then re-arm in period mode
        bus.cap_en = 1'b1;
        bus.mode   = 2'b00;
        tick(3);
        bus.sig_in = 1'b1;
        tick(4);
        bus.mode = 2'b01;
        tick(1);
        check_eq("abort_mode_busy", bus.busy, 0);
        tick(3);
        bus.sig_in = 1'b0;
        tick(6);
        check_eq("abort_mode_strobes", q_val.size(), 0);
        check_eq("abort_mode_hold",    bus.cap_value, 3);
        clear_log();
        repeat (3) pulse(3, 4);
        check_eq("rearm_count",  q_val.size(), 2);
        check_eq("rearm_value0", log_val(0), 7);
        check_eq("rearm_value1", log_val(1), 7);

        // Reset in the middle of a period measurement
        bus.sig_in = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        check_eq("midrst_value", bus.cap_value, 0);
        check_eq("midrst_valid", bus.cap_valid, 0);
        check_eq("midrst_busy",  bus.busy,      0);
        rst = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
